// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell reused LSB first, WIDTH cycles per operation.
// Define SERIAL_SUB_FLAGS_EN to add the registered zero/lt result flags.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_FLAGS_EN
  output logic             zero,
  output logic             lt,
`endif
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  // Holds the difference bits produced so far; the final bit is merged on the last RUN edge.
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             r_zero;
  logic             r_lt;
`endif

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // Full-subtractor cell on the current LSBs and the assembled result word.
  always_comb begin
    w_d        = r_a[0] ^ r_b[0] ^ r_br;
    w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    w_res_next = {w_d, r_res};
    w_last     = (r_cnt == CNT_LAST);
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_br        <= 1'b0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      r_zero      <= 1'b0;
      r_lt        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // in_ready is still low on the first edge after reset, so that edge never accepts.
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_br       <= bin;
            r_cnt      <= '0;
            r_res      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
          r_out_valid <= 1'b0;
        end
        S_RUN: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_br  <= w_br_next;
          r_res <= w_res_next[WIDTH-1:1];
          if (w_last) begin
            r_state     <= S_DONE;
            r_diff      <= w_res_next;
            r_bout      <= w_br_next;
            r_out_valid <= 1'b1;
`ifdef SERIAL_SUB_FLAGS_EN
            r_zero      <= (w_res_next == {WIDTH{1'b0}});
            r_lt        <= w_br_next;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign diff      = r_diff;
  assign bout      = r_bout;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero      = r_zero;
  assign lt        = r_lt;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed cases plus random operands
// checked against an integer-arithmetic reference.
module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero;
  logic         lt;
`endif

  int total = 0;
  int bad   = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout),
`ifdef SERIAL_SUB_FLAGS_EN
    .zero(zero), .lt(lt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: accept, WIDTH RUN cycles, hold in DONE, release.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                       input int hold, input logic noise);
    int           full;
    logic [W-1:0] ed;
    logic         eb;
    full = int'(ta) - int'(tb_) - int'(tbin);
    ed   = W'((full + (1 << W)) % (1 << W));
    eb   = (int'(ta) < int'(tb_) + int'(tbin));
    chk("idle_in_ready", in_ready, 1'b1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_;
    bin       = tbin;
    out_ready = noise;
    tick();
    in_valid = noise;
    a        = W'($urandom);
    b        = W'($urandom);
    bin      = 1'($urandom);
    chk("accept_busy", busy, 1'b1);
    chk("accept_in_ready", in_ready, 1'b0);
    for (int i = 1; i < W; i++) begin
      tick();
      chk("run_out_valid", out_valid, 1'b0);
    end
    tick();
    chk("done_out_valid", out_valid, 1'b1);
    chk("diff", diff, ed);
    chk("bout", bout, eb);
`ifdef SERIAL_SUB_FLAGS_EN
    chk("zero", zero, (ed == '0));
    chk("lt", lt, eb);
`endif
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_diff", diff, ed);
      chk("hold_bout", bout, eb);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    // Offer operands on the release edge: they must not be taken.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    chk("release_out_valid", out_valid, 1'b0);
    chk("release_busy", busy, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);
    chk("kept_diff", diff, ed);
    chk("kept_bout", bout, eb);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_bout", bout, 1'b0);
    #6 rst_n = 1'b1;
    #2;
    chk("pre_edge_in_ready", in_ready, 1'b0);
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    do_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
    do_op(8'h03, 8'h05, 1'b0, 1, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 0, 1'b1);
    do_op(8'hA5, 8'h17, 1'b0, 5, 1'b0);
    do_op(8'h7C, 8'h7C, 1'b0, 0, 1'b0);
    do_op(8'h01, 8'h02, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 2, 1'b1);

    // Reset in the middle of an operation discards it.
    in_valid = 1'b1;
    a        = 8'hAA;
    b        = 8'h55;
    bin      = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_diff", diff, 8'h00);
    chk("abort_bout", bout, 1'b0);
    tick();
    chk("abort_held_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk("abort_never_valid", out_valid, 1'b0);
      chk("abort_idle_ready", in_ready, 1'b1);
    end
    do_op(8'h10, 8'h01, 1'b0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
